spad_seq_ctrl: RTL and testbench

Sequencer that owns one scratchpad instance (one read port, one write port, 1-cycle registered read latency, read data 0 when read enable low) inside a PE. It fills the scratchpad from a valid/ready write stream, then replays the stored words as a valid/ready read stream for a configurable number of passes, for filter/ifmap reuse. A 2-entry output buffer with credit-based issue absorbs downstream backpressure at full throughput.

---
 rtl/spad_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_spad_seq_ctrl.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spad_seq_ctrl.sv
// ---------------------------------------------------------------------------
// spad_seq_ctrl
//
// Owns one scratchpad (1 read port, 1 write port, 1-cycle registered read).
// A job first fills the scratchpad from a valid/ready write stream (unless
// skip_fill is set), then replays words 0..len-1 for `reps` passes as a
// valid/ready read stream. Reads are issued against a 2-entry output FIFO
// using credits, so downstream backpressure never overflows the FIFO while
// still allowing one word per cycle when the consumer is always ready.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   i_start, i_cfg_len,
//   i_cfg_reps, i_cfg_skip_fill   job command and configuration (IDLE only)
//   i_wvalid, o_wready, i_wdata   fill stream
//   o_rvalid, i_rready,
//   o_rdata, o_rlast              replay stream (rlast = last word of a pass)
//   o_busy, o_done                status: not idle / one-cycle completion
//   o_spad_wen/waddr/wdata        scratchpad write port
//   o_spad_ren/raddr              scratchpad read port
//   i_spad_rdata                  scratchpad read data (one cycle after ren)
// ---------------------------------------------------------------------------
module spad_seq_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_BITWIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [ADDR_BITWIDTH:0]   i_cfg_len,
  input  logic [7:0]               i_cfg_reps,
  input  logic                     i_cfg_skip_fill,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [DATA_WIDTH-1:0]    o_rdata,
  output logic                     o_rlast,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_spad_wen,
  output logic [ADDR_BITWIDTH-1:0] o_spad_waddr,
  output logic [DATA_WIDTH-1:0]    o_spad_wdata,
  output logic                     o_spad_ren,
  output logic [ADDR_BITWIDTH-1:0] o_spad_raddr,
  input  logic [DATA_WIDTH-1:0]    i_spad_rdata
);

  localparam int LW = ADDR_BITWIDTH + 1;
  localparam logic [LW-1:0]            DEPTH = {1'b1, {ADDR_BITWIDTH{1'b0}}};
  localparam logic [LW-1:0]            ONE_L = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITWIDTH-1:0] ONE_A = {{(ADDR_BITWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t                  state_reg;
  logic [LW-1:0]           len_reg;
  logic [7:0]              reps_reg;
  logic [LW-1:0]           wcnt_reg;
  logic [ADDR_BITWIDTH-1:0] raddr_reg;
  logic [7:0]              pass_reg;
  logic                    issue_done_reg;
  logic                    inflight_reg;
  logic                    inflight_last_reg;
  logic                    inflight_fin_reg;
  logic                    done_reg;

  // 2-entry output FIFO; each entry carries data, pass-last and job-final tags
  logic [DATA_WIDTH-1:0]   fifo_data [2];
  logic                    fifo_last [2];
  logic                    fifo_fin  [2];
  logic                    rd_ptr_reg;
  logic                    wr_ptr_reg;
  logic [1:0]              cnt_reg;

  logic [LW-1:0] len_eff;
  logic [LW-1:0] len_m1;
  logic          wfire;
  logic          pop;
  logic [2:0]    occ;
  logic          spad_ren;
  logic          raddr_last;
  logic          pass_last;
  logic          final_pop;

  always_comb begin
    len_eff    = (i_cfg_len > DEPTH) ? DEPTH : i_cfg_len;
    len_m1     = len_reg - ONE_L;
    wfire      = (state_reg == FILL) && i_wvalid;
    pop        = (cnt_reg != 2'd0) && i_rready;
    // Words already owed to the FIFO: stored ones not leaving this cycle plus
    // the read still in the scratchpad pipeline. Issue only if a slot is free.
    occ        = {1'b0, cnt_reg} - {2'b00, pop} + {2'b00, inflight_reg};
    spad_ren   = (state_reg == STREAM) && !issue_done_reg && (occ < 3'd2);
    raddr_last = ({1'b0, raddr_reg} == len_m1);
    pass_last  = (pass_reg == reps_reg - 8'd1);
    final_pop  = pop && fifo_fin[rd_ptr_reg];
  end

  assign o_wready     = (state_reg == FILL);
  assign o_spad_wen   = wfire;
  assign o_spad_waddr = wfire ? wcnt_reg[ADDR_BITWIDTH-1:0] : '0;
  assign o_spad_wdata = wfire ? i_wdata : '0;
  assign o_spad_ren   = spad_ren;
  assign o_spad_raddr = spad_ren ? raddr_reg : '0;
  assign o_rvalid     = (cnt_reg != 2'd0);
  assign o_rdata      = o_rvalid ? fifo_data[rd_ptr_reg] : '0;
  assign o_rlast      = o_rvalid & fifo_last[rd_ptr_reg];
  assign o_busy       = (state_reg != IDLE);
  assign o_done       = done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      len_reg           <= '0;
      reps_reg          <= '0;
      wcnt_reg          <= '0;
      raddr_reg         <= '0;
      pass_reg          <= '0;
      issue_done_reg    <= 1'b0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      inflight_fin_reg  <= 1'b0;
      done_reg          <= 1'b0;
      fifo_data[0]      <= '0;
      fifo_data[1]      <= '0;
      fifo_last[0]      <= 1'b0;
      fifo_last[1]      <= 1'b0;
      fifo_fin[0]       <= 1'b0;
      fifo_fin[1]       <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      cnt_reg           <= 2'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start && (len_eff != '0)) begin
            len_reg        <= len_eff;
            reps_reg       <= (i_cfg_reps == 8'd0) ? 8'd1 : i_cfg_reps;
            wcnt_reg       <= '0;
            raddr_reg      <= '0;
            pass_reg       <= '0;
            issue_done_reg <= 1'b0;
            state_reg      <= i_cfg_skip_fill ? STREAM : FILL;
          end
        end
        FILL: begin
          if (wfire) begin
            if (wcnt_reg == len_m1) begin
              wcnt_reg  <= '0;
              state_reg <= STREAM;
            end else begin
              wcnt_reg <= wcnt_reg + ONE_L;
            end
          end
        end
        STREAM: begin
          if (spad_ren) begin
            if (raddr_last) begin
              raddr_reg <= '0;
              if (pass_last) begin
                issue_done_reg <= 1'b1;
              end else begin
                pass_reg <= pass_reg + 8'd1;
              end
            end else begin
              raddr_reg <= raddr_reg + ONE_A;
            end
          end
          // The final word can only be popped after every issue has returned,
          // so the FIFO and pipeline are empty when we drop back to IDLE.
          if (final_pop) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Return path: the scratchpad answers one cycle after the issue.
      inflight_reg      <= spad_ren;
      inflight_last_reg <= raddr_last;
      inflight_fin_reg  <= raddr_last && pass_last;
      if (inflight_reg) begin
        fifo_data[wr_ptr_reg] <= i_spad_rdata;
        fifo_last[wr_ptr_reg] <= inflight_last_reg;
        fifo_fin[wr_ptr_reg]  <= inflight_fin_reg;
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      cnt_reg <= cnt_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_spad_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spad_seq_ctrl: directed bench for spad_seq_ctrl with a behavioural
// scratchpad (registered read, data 0 when ren low) and a negedge monitor
// that logs writes, issues, pops and done pulses.
// ---------------------------------------------------------------------------
module tb_spad_seq_ctrl;

  localparam int DW = 16;
  localparam int AB = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [AB:0]   i_cfg_len;
  logic [7:0]    i_cfg_reps;
  logic          i_cfg_skip_fill;
  logic          i_wvalid;
  logic          o_wready;
  logic [DW-1:0] i_wdata;
  logic          o_rvalid;
  logic          i_rready;
  logic [DW-1:0] o_rdata;
  logic          o_rlast;
  logic          o_busy;
  logic          o_done;
  logic          o_spad_wen;
  logic [AB-1:0] o_spad_waddr;
  logic [DW-1:0] o_spad_wdata;
  logic          o_spad_ren;
  logic [AB-1:0] o_spad_raddr;
  logic [DW-1:0] i_spad_rdata;

  spad_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_BITWIDTH(AB)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_cfg_len(i_cfg_len),
    .i_cfg_reps(i_cfg_reps), .i_cfg_skip_fill(i_cfg_skip_fill),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata),
    .o_rlast(o_rlast), .o_busy(o_busy), .o_done(o_done),
    .o_spad_wen(o_spad_wen), .o_spad_waddr(o_spad_waddr),
    .o_spad_wdata(o_spad_wdata), .o_spad_ren(o_spad_ren),
    .o_spad_raddr(o_spad_raddr), .i_spad_rdata(i_spad_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural scratchpad
  logic [DW-1:0] mem [1 << AB];
  initial i_spad_rdata = '0;
  always @(posedge clk) begin
    if (o_spad_wen) mem[o_spad_waddr] <= o_spad_wdata;
    i_spad_rdata <= o_spad_ren ? mem[o_spad_raddr] : '0;
  end

  logic [56:0] all_outs;
  assign all_outs = {o_wready, o_rvalid, o_rdata, o_rlast, o_busy, o_done,
                     o_spad_wen, o_spad_waddr, o_spad_wdata, o_spad_ren, o_spad_raddr};

  // Monitor
  int            cyc = 0;
  int            outstanding = 0;
  int            credit_viol = 0;
  int            done_cnt = 0;
  int            wready_cnt = 0;
  logic [DW-1:0] pop_d [$];
  logic          pop_l [$];
  int            pop_c [$];
  logic [AB-1:0] ren_a [$];
  int            ren_c [$];
  logic [AB-1:0] wa [$];
  logic [DW-1:0] wd [$];
  int            done_c [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      outstanding <= 0;
    end else begin
      if (o_rvalid && i_rready) begin
        pop_d.push_back(o_rdata);
        pop_l.push_back(o_rlast);
        pop_c.push_back(cyc);
      end
      if (o_spad_ren) begin
        ren_a.push_back(o_spad_raddr);
        ren_c.push_back(cyc);
        if (outstanding - ((o_rvalid && i_rready) ? 1 : 0) >= 2)
          credit_viol <= credit_viol + 1;
      end
      if (o_spad_wen) begin
        wa.push_back(o_spad_waddr);
        wd.push_back(o_spad_wdata);
      end
      if (o_wready) wready_cnt <= wready_cnt + 1;
      if (o_done) begin
        done_cnt <= done_cnt + 1;
        done_c.push_back(cyc);
      end
      outstanding <= outstanding + (o_spad_ren ? 1 : 0) - ((o_rvalid && i_rready) ? 1 : 0);
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = alternate, 2 = random
  int rr_mode = 0;
  initial begin
    i_rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        1:       i_rready = ~i_rready;
        2:       i_rready = 1'($urandom_range(0, 1));
        default: i_rready = 1'b1;
      endcase
    end
  end

  int            errors = 0;
  int            checks = 0;
  int            start_cyc;
  int            done_base;
  logic [DW-1:0] wbuf [1 << AB];   // mirror of the scratchpad contents
  logic [DW-1:0] exp_d [$];
  logic          exp_l [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int reps, input bit skip);
    i_start         = 1'b1;
    i_cfg_len       = 10'(len);
    i_cfg_reps      = 8'(reps);
    i_cfg_skip_fill = skip;
    start_cyc       = cyc;
    done_base       = done_cnt;
    tick();
    i_start = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      i_wvalid = 1'b1;
      i_wdata  = wbuf[i];
      tick();
    end
    i_wvalid = 1'b0;
    i_wdata  = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_cnt == done_base && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (done_cnt == done_base) begin
      errors++;
      $display("FAIL %s_timeout: o_done not seen after %0d cycles, required within %0d", name, k, budget);
    end
    tick();
    tick();
  endtask

  function automatic void build_exp(input int len, input int reps);
    exp_d.delete();
    exp_l.delete();
    for (int p = 0; p < reps; p++)
      for (int a = 0; a < len; a++) begin
        exp_d.push_back(wbuf[a]);
        exp_l.push_back(a == len - 1);
      end
  endfunction

  // -1 = exact match, -2 = length differs, otherwise first differing index
  function automatic int first_diff(input int base);
    if (pop_d.size() - base != exp_d.size()) return -2;
    for (int i = 0; i < exp_d.size(); i++)
      if (pop_d[base + i] !== exp_d[i] || pop_l[base + i] !== exp_l[i]) return i;
    return -1;
  endfunction

  // ------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", o_busy);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_wready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b wready=%b, required 0 0", o_busy, o_wready);
    end
  endtask

  task automatic test_fill_two_passes();
    int pbase = pop_d.size();
    int wbase = wa.size();
    int d;
    int bad;
    wbuf[0] = 16'h0011; wbuf[1] = 16'h0022; wbuf[2] = 16'h0033; wbuf[3] = 16'h0044;
    rr_mode = 0;
    start_job(4, 2, 1'b0);
    checks++;
    if (o_wready !== 1'b1) begin
      errors++;
      $display("FAIL fill_wready_t1: got %b, required 1", o_wready);
    end
    fill(4);
    wait_done("fill2", 100);

    bad = (wa.size() - wbase != 4) ? 1 : 0;
    for (int i = 0; i < 4; i++)
      if (wa[wbase + i] !== 9'(i) || wd[wbase + i] !== wbuf[i]) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill_writes: got %0d writes (first addr %0d data %h), required 4 writes addr 0..3 data 11..44",
               wa.size() - wbase, wa[wbase], wd[wbase]);
    end

    build_exp(4, 2);
    d = first_diff(pbase);
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL fill2_stream: diff at %0d, got %0d words (word %h last %b), required %0d words (word %h last %b)",
               d, pop_d.size() - pbase, pop_d[pbase + (d < 0 ? 0 : d)], pop_l[pbase + (d < 0 ? 0 : d)],
               exp_d.size(), exp_d[d < 0 ? 0 : d], exp_l[d < 0 ? 0 : d]);
    end

    checks++;
    if (pop_c[pbase] !== start_cyc + 7) begin
      errors++;
      $display("FAIL first_pop_latency: got cycle %0d, required %0d", pop_c[pbase], start_cyc + 7);
    end

    bad = 0;
    for (int i = 1; i < 8; i++)
      if (pop_c[pbase + i] !== pop_c[pbase] + i) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill2_throughput: pop cycles %0d..%0d, required 8 consecutive cycles", pop_c[pbase], pop_c[pbase + 7]);
    end

    checks++;
    if (done_cnt - done_base !== 1) begin
      errors++;
      $display("FAIL fill2_done_count: got %0d, required 1", done_cnt - done_base);
    end
    checks++;
    if (done_c[done_c.size() - 1] !== pop_c[pbase + 7] + 1) begin
      errors++;
      $display("FAIL fill2_done_cycle: got %0d, required %0d", done_c[done_c.size() - 1], pop_c[pbase + 7] + 1);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL fill2_busy_after: got %b, required 0", o_busy);
    end
  endtask

  task automatic test_backpressure();
    for (int m = 1; m <= 2; m++) begin
      int pbase = pop_d.size();
      int vbase = credit_viol;
      int d;
      rr_mode = m;
      start_job(4, 2, 1'b0);
      fill(4);
      wait_done("backpressure", 200);
      build_exp(4, 2);
      d = first_diff(pbase);
      checks++;
      if (d != -1) begin
        errors++;
        $display("FAIL bp_stream mode %0d: diff at %0d, got %0d words, required %0d", m, d, pop_d.size() - pbase, exp_d.size());
      end
      checks++;
      if (credit_viol !== vbase) begin
        errors++;
        $display("FAIL bp_credit mode %0d: got %0d issues with no credit, required 0", m, credit_viol - vbase);
      end
      checks++;
      if (done_cnt - done_base !== 1) begin
        errors++;
        $display("FAIL bp_done_count mode %0d: got %0d, required 1", m, done_cnt - done_base);
      end
      checks++;
      if (o_busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_busy_after mode %0d: got %b, required 0", m, o_busy);
      end
    end
    rr_mode = 0;
    tick();
  endtask

  task automatic test_skip_fill();
    int pbase = pop_d.size();
    int rbase = ren_c.size();
    int wrb = wready_cnt;
    int d;
    start_job(3, 0, 1'b1);
    wait_done("skip", 100);
    checks++;
    if (ren_c[rbase] !== start_cyc + 1) begin
      errors++;
      $display("FAIL skip_first_issue: got cycle %0d, required %0d", ren_c[rbase], start_cyc + 1);
    end
    checks++;
    if (wready_cnt !== wrb) begin
      errors++;
      $display("FAIL skip_wready: got %0d wready cycles, required 0", wready_cnt - wrb);
    end
    build_exp(3, 1);
    d = first_diff(pbase);
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL skip_stream: diff at %0d, got %0d words, required %0d (11 22 33, last on 33)", d, pop_d.size() - pbase, exp_d.size());
    end
    checks++;
    if (done_cnt - done_base !== 1) begin
      errors++;
      $display("FAIL skip_done_count: got %0d, required 1", done_cnt - done_base);
    end
  endtask

  task automatic test_max_depth();
    int pbase = pop_d.size();
    int rbase = ren_a.size();
    int d;
    int bad;
    for (int i = 0; i < 512; i++) wbuf[i] = 16'(i * 7 + 16'h0100);
    start_job(512, 1, 1'b0);
    fill(512);
    wait_done("maxdepth", 2000);
    build_exp(512, 1);
    d = first_diff(pbase);
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL max_stream: diff at %0d, got %0d words, required 512 with last only on 511", d, pop_d.size() - pbase);
    end
    bad = (ren_a.size() - rbase != 512) ? 1 : 0;
    for (int i = 0; i < 512; i++)
      if (ren_a[rbase + i] !== 9'(i)) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL max_raddr: got %0d issues, required 512 issues addr 0..511", ren_a.size() - rbase);
    end
    checks++;
    if (done_cnt - done_base !== 1) begin
      errors++;
      $display("FAIL max_done_count: got %0d, required 1", done_cnt - done_base);
    end
    // Length above the depth saturates to the full depth.
    pbase = pop_d.size();
    start_job(600, 1, 1'b1);
    wait_done("saturate", 2000);
    d = first_diff(pbase);
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL len_saturate: diff at %0d, got %0d words, required 512", d, pop_d.size() - pbase);
    end
  endtask

  task automatic test_reset_mid_stream();
    int pbase = pop_d.size();
    int k = 0;
    int d;
    start_job(4, 2, 1'b1);
    while (pop_d.size() - pbase < 2 && k < 50) begin
      tick();
      k++;
    end
    checks++;
    if (pop_d.size() - pbase < 2) begin
      errors++;
      $display("FAIL midreset_wait: got %0d words, required 2", pop_d.size() - pbase);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, required 0", all_outs);
    end
    reset = 1'b0;
    repeat (4) tick();
    checks++;
    if (done_cnt !== done_base || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: done pulses %0d busy %b, required 0 0", done_cnt - done_base, o_busy);
    end
    pbase = pop_d.size();
    start_job(4, 1, 1'b1);
    wait_done("after_reset", 100);
    build_exp(4, 1);
    d = first_diff(pbase);
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL midreset_followup: diff at %0d, got %0d words, required 4", d, pop_d.size() - pbase);
    end
  endtask

  task automatic test_ignored_starts();
    int pbase = pop_d.size();
    int wrb;
    int d;
    wbuf[0] = 16'h00A1; wbuf[1] = 16'h00B2; wbuf[2] = 16'h00C3; wbuf[3] = 16'h00D4;
    start_job(4, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      i_wvalid = 1'b1;
      i_wdata  = wbuf[i];
      if (i == 2) begin
        i_start = 1'b1; i_cfg_len = 10'd2; i_cfg_reps = 8'd5; i_cfg_skip_fill = 1'b1;
      end
      tick();
      i_start = 1'b0;
    end
    i_wvalid = 1'b0;
    i_start = 1'b1; i_cfg_len = 10'd1; i_cfg_reps = 8'd3; i_cfg_skip_fill = 1'b0;
    tick();
    i_start = 1'b0;
    wait_done("ignored", 100);
    build_exp(4, 1);
    d = first_diff(pbase);
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL ignored_stream: diff at %0d, got %0d words, required 4 (A1 B2 C3 D4)", d, pop_d.size() - pbase);
    end
    checks++;
    if (done_cnt - done_base !== 1) begin
      errors++;
      $display("FAIL ignored_done_count: got %0d, required 1", done_cnt - done_base);
    end
    wrb = wready_cnt;
    start_job(0, 1, 1'b0);
    repeat (5) tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_busy: got %b, required 0", o_busy);
    end
    checks++;
    if (wready_cnt !== wrb) begin
      errors++;
      $display("FAIL len0_wready: got %0d wready cycles, required 0", wready_cnt - wrb);
    end
    checks++;
    if (done_cnt !== done_base) begin
      errors++;
      $display("FAIL len0_done: got %0d pulses, required 0", done_cnt - done_base);
    end
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    i_cfg_len = '0;
    i_cfg_reps = '0;
    i_cfg_skip_fill = 1'b0;
    i_wvalid = 1'b0;
    i_wdata = '0;
    tick();
    test_reset();
    test_fill_two_passes();
    test_backpressure();
    test_skip_fill();
    test_max_depth();
    test_reset_mid_stream();
    test_ignored_starts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
